// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: FSM state encoding, PC step and default sizing.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP            = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int          DEFAULT_IMEM_WORDS = 32;

endpackage

// File: rtl/next_pc_sel.sv
// Redirect-priority mux: jr beats jump beats branch; jump target keeps the 256 MB region of the link PC.
module next_pc_sel
  import fetch_pc_unit_pkg::*;
(
  input  logic [3:0]  link_region_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  output logic        redirect_o,
  output logic [31:0] target_o
);

  always_comb begin
    redirect_o = jr_i | jump_i | branch_i;
    target_o   = branch_target_i;
    if (jr_i) begin
      target_o = jr_target_i;
    end else if (jump_i) begin
      target_o = {link_region_i, jump_index_i, 2'b00};
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch PC unit: IDLE/RUN/HALT/FAULT FSM, PC register and one-deep fetched-instruction register.
// Optional fetch-address bounds checking is enabled by defining FETCH_BOUNDS_CHECK_EN.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        instr_ready_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  input  logic        halt_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        instr_valid_o,
  output logic        fault_o,
  output logic [1:0]  state_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  seq_pc;
  logic [31:0]  redirect_target;
  logic         redirect;
  logic         adv;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  logic fault_q, fault_d;

  function automatic logic pc_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= IMEM_LIMIT);
  endfunction
`endif

  assign pc_plus4_o = instr_pc_q + PC_STEP;
  assign seq_pc     = pc_q + PC_STEP;

  next_pc_sel u_next_pc_sel (
    .link_region_i   (pc_plus4_o[31:28]),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_index_i    (jump_index_i),
    .jr_i            (jr_i),
    .jr_target_i     (jr_target_i),
    .redirect_o      (redirect),
    .target_o        (redirect_target)
  );

  assign adv = (state_q == ST_RUN) & ~stall_i & (~valid_q | instr_ready_i) & ~redirect;

  // Halt outranks redirects, which outrank sequential advance; redirects ignore stall and ready.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
`ifdef FETCH_BOUNDS_CHECK_EN
    fault_d    = fault_q;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        if (halt_i) begin
          state_d = ST_HALT;
          valid_d = 1'b0;
        end else if (redirect) begin
          valid_d = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
          if (pc_bad(redirect_target)) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else
`endif
          pc_d = redirect_target;
        end else if (adv) begin
`ifdef FETCH_BOUNDS_CHECK_EN
          if (pc_bad(seq_pc)) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            valid_d = 1'b0;
          end else
`endif
          begin
            instr_d    = instr_i;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = seq_pc;
          end
        end else if (instr_ready_i) begin
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      valid_q    <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  assign pc_o          = pc_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = valid_q;
  assign state_o       = state_q;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign fault_o       = fault_q;
`else
  assign fault_o       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios then random traffic against a behavioural model.
module tb_fetch_pc_unit;

  localparam int IMEM_WORDS = 32;
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        ready, stall, branch, jump, jr, halt;
  logic [31:0] branch_target, jr_target;
  logic [25:0] jump_index;
  logic [31:0] pc, instr_out, instr_pc, pc_plus4;
  logic        valid, fault;
  logic [1:0]  state;

  logic [31:0] imem [64];

  int checks = 0;
  int fails  = 0;

  // Behavioural reference state
  int unsigned m_state;
  logic [31:0] m_pc, m_instr, m_ipc;
  bit          m_valid, m_fault;

  fetch_pc_unit #(.RESET_PC(32'h0), .IMEM_WORDS(IMEM_WORDS)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .instr_i         (instr),
    .instr_ready_i   (ready),
    .stall_i         (stall),
    .branch_i        (branch),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_index_i    (jump_index),
    .jr_i            (jr),
    .jr_target_i     (jr_target),
    .halt_i          (halt),
    .pc_o            (pc),
    .instr_o         (instr_out),
    .instr_pc_o      (instr_pc),
    .pc_plus4_o      (pc_plus4),
    .instr_valid_o   (valid),
    .fault_o         (fault),
    .state_o         (state)
  );

  assign instr = imem[pc[7:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit isBad(input logic [31:0] a);
    return BOUNDS_EN && (((a % 4) != 0) || (longint'(a) >= longint'(IMEM_WORDS) * 4));
  endfunction

  task automatic modelStep();
    logic [31:0] tgt;
    logic [31:0] nxt;
    if (!rst) begin
      m_state = 0; m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_valid = 0; m_fault = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (halt) begin
        m_state = 2;
        m_valid = 0;
      end else if (jr || jump || branch) begin
        if (jr) tgt = jr_target;
        else if (jump) tgt = ((m_ipc + 32'd4) & 32'hF000_0000) | (32'(jump_index) << 2);
        else tgt = branch_target;
        m_valid = 0;
        if (isBad(tgt)) begin m_state = 3; m_fault = 1; end
        else m_pc = tgt;
      end else if (!stall && (!m_valid || ready)) begin
        nxt = m_pc + 32'd4;
        if (isBad(nxt)) begin
          m_state = 3; m_fault = 1; m_valid = 0;
        end else begin
          m_instr = imem[m_pc[7:2]];
          m_ipc   = m_pc;
          m_valid = 1;
          m_pc    = nxt;
        end
      end else if (ready) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock with the inputs currently driven, updating the model alongside.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    checkEq({tag, ".pc"},       pc,        m_pc);
    checkEq({tag, ".instr"},    instr_out, m_instr);
    checkEq({tag, ".instr_pc"}, instr_pc,  m_ipc);
    checkEq({tag, ".pc_plus4"}, pc_plus4,  m_ipc + 32'd4);
    checkEq({tag, ".valid"},    32'(valid), 32'(m_valid));
    checkEq({tag, ".fault"},    32'(fault), 32'(m_fault));
    checkEq({tag, ".state"},    32'(state), 32'(m_state));
  endtask

  task automatic clearInputs();
    ready = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0; jr = 1'b0; halt = 1'b0;
    branch_target = 32'h0; jr_target = 32'h0; jump_index = 26'h0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("reset");
    rst = 1'b1;
  endtask

  initial begin
    bit reached;
    logic [31:0] held_pc;
    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    m_state = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_fault = 0;
    clearInputs();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset and straight-line fetch of A, B, C
    doReset();
    checkEq("reset_state_const", 32'(state), 32'd0);
    checkEq("reset_pc_const", pc, 32'h0);
    ready = 1'b1;
    applyStimulus();
    checkOutput("idle_to_run");
    checkEq("run_after_idle", 32'(state), 32'd1);
    checkEq("no_fetch_in_idle", 32'(valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("seq_fetch");
      checkEq("seq_instr_const", instr_out, imem[i]);
      checkEq("seq_ipc_const", instr_pc, 32'(i * 4));
    end

    // Decode back-pressure holds everything
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("backpressure");
      checkEq("bp_instr_held", instr_out, imem[2]);
      checkEq("bp_pc_held", pc, 32'hC);
    end
    ready = 1'b1;
    applyStimulus();
    checkOutput("bp_resume");
    checkEq("bp_resume_instr", instr_out, imem[3]);

    // jr beats branch and overrides stall
    stall = 1'b1; branch = 1'b1; branch_target = 32'h10; jr = 1'b1; jr_target = 32'h20;
    applyStimulus();
    checkOutput("jr_over_branch");
    checkEq("jr_pc_const", pc, 32'h20);
    checkEq("jr_squash", 32'(valid), 32'd0);
    clearInputs();

    // Jump at instr_pc 0x8
    doReset();
    ready = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("pre_jump");
    checkEq("pre_jump_ipc", instr_pc, 32'h8);
    jump = 1'b1; jump_index = 26'd3;
    applyStimulus();
    checkOutput("jump3");
    checkEq("jump3_pc_const", pc, 32'hC);
    jump_index = 26'd5;
    applyStimulus();
    checkOutput("jump5");
    clearInputs();

    // Sequential fetch up to the end of instruction memory
    doReset();
    ready = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 64 && !reached; i++) begin
      applyStimulus();
      if (pc == 32'h7C) reached = 1'b1;
    end
    checkEq("reach_7c", pc, 32'h7C);
    applyStimulus();
    checkOutput("mem_end");
    if (BOUNDS_EN) begin
      checkEq("mem_end_fault", 32'(fault), 32'd1);
      checkEq("mem_end_pc", pc, 32'h7C);
    end else begin
      checkEq("mem_end_pc", pc, 32'h80);
      checkEq("mem_end_fault", 32'(fault), 32'd0);
    end
    clearInputs();

    // Halt wins over branch and sticks until reset
    doReset();
    ready = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus();
    held_pc = pc;
    halt = 1'b1; branch = 1'b1; branch_target = 32'h40;
    applyStimulus();
    checkOutput("halt_branch");
    checkEq("halt_state", 32'(state), 32'd2);
    checkEq("halt_pc", pc, held_pc);
    clearInputs();
    ready = 1'b1; jr = 1'b1; jr_target = 32'h30;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("halt_hold");
    end
    checkEq("halt_pc_frozen", pc, held_pc);
    clearInputs();
    rst = 1'b0;
    applyStimulus();
    checkOutput("halt_reset");
    checkEq("halt_reset_idle", 32'(state), 32'd0);
    rst = 1'b1;

    // Random traffic, including mid-operation resets
    doReset();
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 59) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      ready         = ($urandom_range(0, 2) != 0);
      branch        = ($urandom_range(0, 9) == 0);
      jump          = ($urandom_range(0, 11) == 0);
      jr            = ($urandom_range(0, 14) == 0);
      halt          = ($urandom_range(0, 149) == 0);
      branch_target = 32'($urandom_range(0, 40)) << 2;
      jr_target     = (32'($urandom_range(0, 40)) << 2) | 32'($urandom_range(0, 7) == 0);
      jump_index    = 26'($urandom_range(0, 40));
      applyStimulus();
      checkOutput("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
